// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: slice width,
// per-stage control record and the stage-count helper.
package cla_pkg;

  localparam int SLICE_W = 4;

  // Control part of a stage register; sum and residual operands are WIDTH-dependent
  // and are kept as vectors alongside it.
  typedef struct packed {
    logic v;
    logic c;
    logic msb_a;
    logic msb_b;
  } stage_ctl_t;

  function automatic int stages_of(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/cla_4_bit.sv
// Combinational 4-bit carry-lookahead slice.
module cla_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_pipe_stage.sv
// One pipeline stage: adds nibble K with a CLA slice and registers the
// partial sum, carry and remaining operands behind a valid/ready handshake.
module cla_pipe_stage
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  stage_ctl_t       ctl_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ready_i,
  output logic             ready_o,
  output stage_ctl_t       ctl_o,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

  logic [SLICE_W-1:0] s_nib;
  logic               c_nib;
  logic [WIDTH-1:0]   sum_nxt;

  cla_4_bit u_slice (
    .a    (a_i[K*SLICE_W +: SLICE_W]),
    .b    (b_i[K*SLICE_W +: SLICE_W]),
    .cin  (ctl_i.c),
    .sum  (s_nib),
    .cout (c_nib)
  );

  always_comb begin
    sum_nxt = sum_i;
    sum_nxt[K*SLICE_W +: SLICE_W] = s_nib;
  end

  // An empty slot accepts regardless of what sits downstream, so bubbles collapse.
  assign ready_o = ~ctl_o.v | ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_o <= '0;
      sum_o <= '0;
      a_o   <= '0;
      b_o   <= '0;
    end else if (ready_o) begin
      ctl_o.v <= ctl_i.v;
      if (ctl_i.v) begin
        ctl_o.c     <= c_nib;
        ctl_o.msb_a <= ctl_i.msb_a;
        ctl_o.msb_b <= ctl_i.msb_b;
        sum_o       <= sum_nxt;
        a_o         <= a_i;
        b_o         <= b_i;
      end
    end
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Streaming WIDTH-bit adder: one 4-bit CLA slice per pipeline stage, carry
// registered between stages, valid/ready flow control with bubble collapse.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = stages_of(WIDTH);

  if (((WIDTH % SLICE_W) != 0) || (WIDTH < 8)) begin : g_width_chk
    $fatal(1, "cla_pipe_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  // Index k is the input of stage k; index STAGES is the last stage's register.
  stage_ctl_t       ctl_p [STAGES+1];
  logic [WIDTH-1:0] sum_p [STAGES+1];
  logic [WIDTH-1:0] opa_p [STAGES+1];
  logic [WIDTH-1:0] opb_p [STAGES+1];
  logic             rdy_p [STAGES+1];
  logic             unused_ops;

  assign ctl_p[0]      = '{v: in_valid, c: cin, msb_a: a[WIDTH-1], msb_b: b[WIDTH-1]};
  assign sum_p[0]      = '0;
  assign opa_p[0]      = a;
  assign opb_p[0]      = b;
  assign rdy_p[STAGES] = out_ready;
  assign in_ready      = rdy_p[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_pipe_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .ctl_i   (ctl_p[k]),
      .sum_i   (sum_p[k]),
      .a_i     (opa_p[k]),
      .b_i     (opb_p[k]),
      .ready_i (rdy_p[k+1]),
      .ready_o (rdy_p[k]),
      .ctl_o   (ctl_p[k+1]),
      .sum_o   (sum_p[k+1]),
      .a_o     (opa_p[k+1]),
      .b_o     (opb_p[k+1])
    );
  end

  // Operands are fully consumed by the last slice.
  assign unused_ops = ^{opa_p[STAGES], opb_p[STAGES]};

  assign out_valid = ctl_p[STAGES].v;
  assign sum       = sum_p[STAGES];
  assign cout      = ctl_p[STAGES].c;
  assign ovf       = (ctl_p[STAGES].msb_a == ctl_p[STAGES].msb_b)
                   && (sum_p[STAGES][WIDTH-1] != ctl_p[STAGES].msb_a);

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed corner cases plus randomized streaming
// against an arithmetic reference model and an in-order scoreboard.
module tb_cla_pipe_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = WIDTH / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_out   = 0;
  logic [17:0] exp_q[$];
  logic [17:0] last_res = '0;

  cla_pipe_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: integer arithmetic, overflow as "true signed result out of range".
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic ci);
    int unsigned u;
    int          s;
    logic        o;
    u = 32'(x) + 32'(y) + 32'(ci);
    s = int'($signed(x)) + int'($signed(y)) + int'(ci);
    o = (s > 32767) || (s < -32768);
    return {o, u[16], u[15:0]};
  endfunction

  function automatic logic [15:0] rand_op();
    int unsigned sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       return 16'hFFFF;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Scoreboard: sampled on the falling edge, between driver updates.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            check("stray_out", 32'(out_valid), 32'd0);
          end else begin
            last_res = {ovf, cout, sum};
            check("result", 32'({ovf, cout, sum}), 32'(exp_q.pop_front()));
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci, output int waits);
    a = x;
    b = y;
    cin = ci;
    in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int lat;
    int base;
    bit rnd_done;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Carry out, with first-result latency measured in falling edges after acceptance
    send(16'hFFFF, 16'h0001, 1'b0, w);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check("latency", 32'(lat), 32'(STAGES));
    drain();
    check("carry_out", 32'(last_res), 32'({1'b0, 1'b1, 16'h0000}));

    send(16'h7FFF, 16'h0001, 1'b0, w);
    drain();
    check("ovf_pos", 32'(last_res), 32'({1'b1, 1'b0, 16'h8000}));
    send(16'h8000, 16'h8000, 1'b0, w);
    drain();
    check("ovf_neg", 32'(last_res), 32'({1'b1, 1'b1, 16'h0000}));
    send(16'hFFFF, 16'h0000, 1'b1, w);
    drain();
    check("cin_ripple", 32'(last_res), 32'({1'b0, 1'b1, 16'h0000}));

    // Backpressure: 8 back-to-back ops, 5-cycle stall after the first result
    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), w);
      end
      begin
        int          t;
        bit          fell;
        logic [15:0] held;
        t = 0;
        fell = 1'b0;
        held = '0;
        while (!out_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (c == 0) held = sum;
          else check("bp_sum_stable", 32'(sum), 32'(held));
          if (c < 3 && !in_ready) fell = 1'b1;
        end
        check("bp_in_ready_fell", 32'(fell), 32'd1);
        check("bp_valid_held", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 32'(n_out - base), 32'd8);

    // Bubble collapse: gaps upstream must not cost capacity under a stall
    base = n_out;
    out_ready = 1'b0;
    send(16'h0101, 16'h0202, 1'b0, w);
    repeat (2) @(posedge clk);
    #1;
    send(16'h1010, 16'h2020, 1'b1, w);
    check("bub_accept_2", 32'(w), 32'd0);
    send(16'hAAAA, 16'h5555, 1'b0, w);
    check("bub_accept_3", 32'(w), 32'd0);
    send(16'h8001, 16'h8001, 1'b0, w);
    check("bub_accept_4", 32'(w), 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bub_full_in_ready", 32'(in_ready), 32'd0);
    check("bub_full_valid", 32'(out_valid), 32'd1);
    check("bub_first_sum", 32'(sum), 32'h0303);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    check("bub_count", 32'(n_out - base), 32'd4);

    // Randomized stream with random downstream stalls
    base = n_out;
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), w);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("rnd_count", 32'(n_out - base), 32'd150);

    // Reset mid-flight discards everything in the pipe
    base = n_out;
    out_ready = 1'b1;
    send(16'h1111, 16'h1111, 1'b0, w);
    send(16'h2222, 16'h0101, 1'b1, w);
    send(16'h3333, 16'h4444, 1'b0, w);
    send(16'h0F0F, 16'h0F0F, 1'b0, w);
    check("rst_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_sum", 32'(sum), 32'd0);
    check("rst_mid_cout", 32'(cout), 32'd0);
    check("rst_mid_ovf", 32'(ovf), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(16'h1234, 16'h4321, 1'b0, w);
    drain();
    check("post_rst_sum", 32'(last_res), 32'({1'b0, 1'b0, 16'h5555}));
    check("post_rst_count", 32'(n_out - base), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Pipelined WIDTH-bit adder built from 4-bit carry-lookahead slices, one slice per pipeline stage, with the inter-slice carry held in a register between stages. It sits directly upstream of the lab's datapath consumers. It turns the team's combinational 4-bit CLA slice into a throughput-one, valid/ready streaming adder for operand widths the single slice cannot cover.

## Interface
- WIDTH, 16, operand width; must be a multiple of 4 and at least 8.
- STAGES, WIDTH/4, derived; number of slices and pipeline stages. Not overridable.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset. Assertion clears state immediately; deassertion is synchronous to clk.
- in_valid  input  1  operand word valid.
- in_ready  output  1  stage 0 can accept this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry in to bit 0.
- out_valid  output  1  result valid (driven by the last stage's valid bit).
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  A + B + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB].

## Operation
- Stage k (k = 0..STAGES-1) adds nibble k of the operands using one 4-bit CLA slice.
  - The slice's carry-in is cin for k = 0, or the carry registered by stage k-1 for k > 0.
- Each stage register holds:
  - valid bit v[k];
  - completed sum nibbles 0..k;
  - carry out of slice k;
  - unconsumed operand nibbles k+1..STAGES-1 of A and B;
  - the MSBs of A and B, for the overflow computation.
- Handshake is per stage:
  - ready[k] = ~v[k] | ready[k+1], with ready[STAGES] = out_ready; in_ready = ready[0].
  - Stage k loads when ready[k]. It takes v[k-1] from the previous stage, or in_valid for k = 0.
  - The data registers of a stage load only when the incoming valid is 1. Bubbles do not disturb data.
- A transfer occurs on an edge where valid & ready are both 1. Inputs are sampled only on in_valid & in_ready.
- Bubbles collapse: a stalled output does not block upstream stages that hold empty slots.
- Results leave in acceptance order; no reordering and no drops.
- Width rule: all arithmetic is unsigned modulo 2^WIDTH.
  - cout is the raw carry out of the top slice.
  - ovf is computed in the last stage from the registered MSBs and sum[WIDTH-1].

## Timing
- Reset values (asynchronous on rst_n low):
  - all v[k] = 0 and all stage data/carry registers = 0;
  - out_valid = 0, sum = 0, cout = 0, ovf = 0;
  - in_ready = 1 in the first cycle after reset. It is combinational and also reads 1 while in reset.
- Latency: an operand accepted at edge n, with no stall, produces out_valid = 1 after edge n+STAGES-1, i.e. edge n+3 for WIDTH=16.
- Throughput: one result per cycle while out_ready = 1.
- in_ready depends combinationally on out_ready through the ready chain. No other combinational input-to-output path exists.
- Full pipeline with out_ready = 0: in_ready = 0, and sum/cout/ovf stay stable until the transfer.
- Simultaneous accept and emit on a full pipeline with out_ready = 1: all stages shift; no bubble is inserted.
- out_valid = 1 with out_ready = 0: the holding stage keeps its output unchanged across any number of cycles.
- Reset mid-operation: all in-flight results are discarded, never emitted, and all outputs return to their reset values.

## Structure
- Shared package cla_pkg:
  - SLICE_W = 4;
  - the stage-register typedef (valid, carry, sum bits, residual operands, MSBs);
  - the function computing STAGES from WIDTH.
- One natural sub-module: cla_pipe_stage.
  - Wraps one existing cla_4_bit instance plus the stage register and its ready logic.
  - Instantiated STAGES times in a generate loop.
- WIDTH legality (multiple of 4, ≥ 8) is checked at elaboration with a fatal error.

## Test plan
- Carry out: a=0xFFFF, b=0x0001, cin=0 → after edge n+3: sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Carry-in propagating through every stage: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0.
- Backpressure:
  - Stimulus: stream 8 random pairs back-to-back; hold out_ready=0 from the cycle after the first out_valid for 5 cycles.
  - Required: in_ready falls within 3 cycles of the stall, sum is stable throughout the stall, and all 8 results arrive in order and match the scoreboard.
- Bubble collapse: accept one op, idle 2 cycles, accept a second with out_ready=0 → both are held in adjacent stages and in_ready stays 1 until STAGES ops are buffered.
- Reset mid-flight: accept 3 ops, assert rst_n=0 for 1 cycle at edge n+2 → out_valid=0, sum=0, cout=0 immediately. After release, no stale result is ever emitted, and a new op 0x1234+0x4321 yields 0x5555.
